// File: rtl/dpram_fifo_pkg.sv
// Shared constants and width helpers for the DPRAM-backed FIFO controller.
package dpram_fifo_pkg;

    localparam int unsigned OB_DEPTH = 2;

    function automatic int unsigned ptr_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

    // Level counts RAM words plus one in-flight read plus the output buffer.
    function automatic int unsigned lvl_w(input int unsigned depth);
        return $clog2(depth) + 2;
    endfunction

endpackage

// File: rtl/dpram_fifo_obuf.sv
// Two-entry output skid buffer fed by the DPRAM read data one cycle after each read.
module dpram_fifo_obuf
    import dpram_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_flush,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_pop,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [1:0]            o_cnt
);

    logic [DATA_WIDTH-1:0] r_mem [OB_DEPTH];
    logic                  r_head;
    logic [1:0]            r_cnt;
    logic                  w_tail;

    // Slot after the newest entry; a full buffer never receives a push.
    assign w_tail = r_head ^ r_cnt[0];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < OB_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_head <= 1'b0;
            r_cnt  <= 2'd0;
        end else if (i_flush) begin
            r_head <= 1'b0;
            r_cnt  <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[w_tail] <= i_data;
            end
            if (i_pop) begin
                r_head <= ~r_head;
            end
            r_cnt <= r_cnt + 2'(i_push) - 2'(i_pop);
        end
    end

    assign o_valid = (r_cnt != 2'd0);
    assign o_data  = r_mem[r_head];
    assign o_cnt   = r_cnt;

endmodule

// File: rtl/dpram_fifo_ctrl.sv
// FIFO controller driving an external synchronous dual-port RAM (port A write, port B read).
module dpram_fifo_ctrl
    import dpram_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 1024
) (
    input  logic                      CLK,
    input  logic                      RSTN,
    input  logic                      FLUSH,
    input  logic                      IN_VALID,
    output logic                      IN_READY,
    input  logic [DATA_WIDTH-1:0]     IN_DATA,
    output logic                      OUT_VALID,
    input  logic                      OUT_READY,
    output logic [DATA_WIDTH-1:0]     OUT_DATA,
    output logic [lvl_w(DEPTH)-1:0]   LEVEL,
    output logic                      CENA,
    output logic                      WENA,
    output logic [ptr_w(DEPTH)-1:0]   AA,
    output logic [DATA_WIDTH-1:0]     DA,
    output logic                      CENB,
    output logic                      WENB,
    output logic [ptr_w(DEPTH)-1:0]   AB,
    input  logic [DATA_WIDTH-1:0]     QB
);

    localparam int unsigned AW = ptr_w(DEPTH);
    localparam int unsigned LW = lvl_w(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic          r_inflight;
    logic [LW-1:0] r_level;

    logic [PW-1:0] w_ram_cnt;
    logic          w_wr;
    logic          w_rd;
    logic          w_out_xfer;
    logic          w_ob_valid;
    logic [1:0]    w_ob_cnt;
    logic [2:0]    w_ob_pending;

    // Pointers carry one extra bit so a full RAM is distinguishable from empty.
    assign w_ram_cnt = r_wptr - r_rptr;

    assign IN_READY     = RSTN && !FLUSH && (w_ram_cnt < PW'(DEPTH));
    assign w_wr         = IN_VALID && IN_READY;
    assign w_out_xfer   = w_ob_valid && OUT_READY;

    // Only read when the buffer is sure to have room for the word a cycle later.
    assign w_ob_pending = 3'(w_ob_cnt) + 3'(r_inflight) - 3'(w_out_xfer);
    assign w_rd         = (w_ram_cnt != '0) && !FLUSH && (w_ob_pending < 3'(OB_DEPTH));

    assign CENA = !w_wr;
    assign WENA = !w_wr;
    assign AA   = r_wptr[AW-1:0];
    assign DA   = w_wr ? IN_DATA : '0;

    assign CENB = !w_rd;
    assign WENB = 1'b1;
    assign AB   = r_rptr[AW-1:0];

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_inflight <= 1'b0;
            r_level    <= '0;
        end else if (FLUSH) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_inflight <= 1'b0;
            r_level    <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_rd) begin
                r_rptr <= r_rptr + PW'(1);
            end
            r_inflight <= w_rd;
            r_level    <= r_level + LW'(w_wr) - LW'(w_out_xfer);
        end
    end

    dpram_fifo_obuf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_obuf (
        .i_clk   (CLK),
        .i_rst_n (RSTN),
        .i_flush (FLUSH),
        .i_push  (r_inflight && !FLUSH),
        .i_data  (QB),
        .i_pop   (w_out_xfer),
        .o_valid (w_ob_valid),
        .o_data  (OUT_DATA),
        .o_cnt   (w_ob_cnt)
    );

    assign OUT_VALID = w_ob_valid;
    assign LEVEL     = r_level;

    a_no_addr_collision: assert property (@(posedge CLK) disable iff (!RSTN)
        !(!CENA && !CENB && (AA == AB)));

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Directed bench for dpram_fifo_ctrl with a behavioural DPRAM and an ordering scoreboard.
module tb_dpram_fifo_ctrl;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 2;
    localparam int unsigned LW    = 4;

    logic          CLK = 1'b0;
    logic          RSTN = 1'b0;
    logic          FLUSH = 1'b0;
    logic          IN_VALID = 1'b0;
    logic          IN_READY;
    logic [DW-1:0] IN_DATA = '0;
    logic          OUT_VALID;
    logic          OUT_READY = 1'b0;
    logic [DW-1:0] OUT_DATA;
    logic [LW-1:0] LEVEL;
    logic          CENA;
    logic          WENA;
    logic [AW-1:0] AA;
    logic [DW-1:0] DA;
    logic          CENB;
    logic          WENB;
    logic [AW-1:0] AB;
    logic [DW-1:0] QB;

    int n_checks = 0;
    int n_errors = 0;
    int n_out    = 0;
    int n_coll   = 0;
    int sent;
    int k;
    int base_out;

    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] ram [DEPTH];

    logic [DW-1:0] t1_in [7] = '{32'h11, 32'h22, 32'h33, 32'h0, 32'h0, 32'h0, 32'h0};
    logic          t1_iv [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic          t1_ev [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [DW-1:0] t1_ed [7] = '{32'h0, 32'h0, 32'h0, 32'h11, 32'h22, 32'h33, 32'h0};

    dpram_fifo_ctrl #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .CLK       (CLK),
        .RSTN      (RSTN),
        .FLUSH     (FLUSH),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .IN_DATA   (IN_DATA),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OUT_DATA  (OUT_DATA),
        .LEVEL     (LEVEL),
        .CENA      (CENA),
        .WENA      (WENA),
        .AA        (AA),
        .DA        (DA),
        .CENB      (CENB),
        .WENB      (WENB),
        .AB        (AB),
        .QB        (QB)
    );

    always #5 CLK = ~CLK;

    // Synchronous DPRAM; read data is garbage on every cycle without a read.
    always @(posedge CLK) begin
        if (!CENA && !WENA) ram[AA] <= DA;
        if (!CENB) QB <= ram[AB];
        else       QB <= $urandom();
        if (!CENA && !CENB && (AA == AB)) n_coll++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Ordering scoreboard: every OUT transfer must match the oldest accepted IN word.
    always @(negedge CLK) begin
        if (RSTN) begin
            if (OUT_VALID && OUT_READY) begin
                n_out++;
                chk("sb_has_word", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    chk("sb_data", 64'(OUT_DATA), 64'(exp_q[0]));
                    void'(exp_q.pop_front());
                end
            end
            if (IN_VALID && IN_READY) exp_q.push_back(IN_DATA);
        end
    end

    task automatic drive(input logic iv, input logic [DW-1:0] d, input logic ordy);
        IN_VALID  = iv;
        IN_DATA   = d;
        OUT_READY = ordy;
        @(negedge CLK);
    endtask

    task automatic adv();
        @(posedge CLK);
        #1;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (LEVEL != '0 && n < 50) begin
            drive(1'b0, DW'(0), 1'b1);
            adv();
            n++;
        end
        drive(1'b0, DW'(0), 1'b1);
        chk({tag, "_level"}, 64'(LEVEL), 64'd0);
        chk({tag, "_ovalid"}, 64'(OUT_VALID), 64'd0);
        chk({tag, "_sb_left"}, 64'(exp_q.size()), 64'd0);
        adv();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset values, with a write request pending that must be ignored.
        IN_VALID = 1'b1;
        IN_DATA  = 32'hDEAD_BEEF;
        @(negedge CLK);
        chk("rst_in_ready", 64'(IN_READY), 64'd0);
        chk("rst_out_valid", 64'(OUT_VALID), 64'd0);
        chk("rst_cena", 64'(CENA), 64'd1);
        chk("rst_cenb", 64'(CENB), 64'd1);
        chk("rst_wena_wenb", 64'({WENA, WENB}), 64'd3);
        chk("rst_aa_ab", 64'({AA, AB}), 64'd0);
        chk("rst_da", 64'(DA), 64'd0);
        chk("rst_out_data", 64'(OUT_DATA), 64'd0);
        chk("rst_level", 64'(LEVEL), 64'd0);
        adv();
        RSTN = 1'b1;

        // Three back-to-back words: valid out in cycles 3..5.
        for (int c = 0; c < 7; c++) begin
            drive(t1_iv[c], t1_in[c], 1'b1);
            if (c == 0) begin
                chk("t1_in_ready", 64'(IN_READY), 64'd1);
                chk("t1_cena", 64'({CENA, WENA}), 64'd0);
                chk("t1_aa", 64'(AA), 64'd0);
                chk("t1_da", 64'(DA), 64'h11);
            end
            if (c == 1) chk("t1_rd_issue", 64'({CENB, WENB, AB}), 64'b0100);
            if (c == 3) chk("t1_level3", 64'(LEVEL), 64'd3);
            if (c == 6) chk("t1_level0", 64'(LEVEL), 64'd0);
            chk($sformatf("t1_ovalid_c%0d", c), 64'(OUT_VALID), 64'(t1_ev[c]));
            if (t1_ev[c]) chk($sformatf("t1_odata_c%0d", c), 64'(OUT_DATA), 64'(t1_ed[c]));
            adv();
        end

        // Fill with OUT stalled: 4 RAM words plus 2 buffered, then backpressure.
        for (int c = 0; c < 6; c++) begin
            drive(1'b1, DW'(32'h100 + c), 1'b0);
            chk("t2_fill_ready", 64'(IN_READY), 64'd1);
            adv();
        end
        drive(1'b0, DW'(0), 1'b0);
        chk("t2_full_ready", 64'(IN_READY), 64'd0);
        chk("t2_full_level", 64'(LEVEL), 64'd6);
        chk("t2_full_ovalid", 64'(OUT_VALID), 64'd1);
        chk("t2_full_odata", 64'(OUT_DATA), 64'h100);
        adv();
        drive(1'b0, DW'(0), 1'b0);
        chk("t2_hold_odata", 64'(OUT_DATA), 64'h100);
        adv();
        drive(1'b0, DW'(0), 1'b1);
        adv();
        drive(1'b0, DW'(0), 1'b0);
        chk("t2_reopen_ready", 64'(IN_READY), 64'd1);
        chk("t2_reopen_level", 64'(LEVEL), 64'd5);
        chk("t2_reopen_odata", 64'(OUT_DATA), 64'h101);
        adv();
        drain("t2");

        // Stream 0..9 with OUT_READY toggling; crosses the pointer wrap twice.
        sent = 0;
        k = 0;
        base_out = n_out;
        while ((n_out - base_out) < 10 && k < 80) begin
            drive(sent < 10, DW'(sent), k[0] == 1'b0);
            if (IN_VALID && IN_READY) sent++;
            adv();
            k++;
        end
        chk("t3_sent", 64'(sent), 64'd10);
        chk("t3_recv", 64'(n_out - base_out), 64'd10);
        drain("t3");

        // Flush with LEVEL=5 and a read in flight.
        for (int c = 0; c < 5; c++) begin
            drive(1'b1, DW'(32'h200 + c), 1'b0);
            adv();
        end
        drive(1'b1, DW'(32'h205), 1'b1);
        chk("t4_rd_inflight", 64'(CENB), 64'd0);
        adv();
        FLUSH = 1'b1;
        drive(1'b1, DW'(32'hEE), 1'b0);
        chk("t4_pre_level", 64'(LEVEL), 64'd5);
        chk("t4_flush_ready", 64'(IN_READY), 64'd0);
        chk("t4_flush_cen", 64'({CENA, CENB}), 64'd3);
        adv();
        FLUSH = 1'b0;
        exp_q.delete();
        base_out = n_out;
        drive(1'b1, DW'(32'hAB), 1'b0);
        chk("t4_post_level", 64'(LEVEL), 64'd0);
        chk("t4_post_ovalid", 64'(OUT_VALID), 64'd0);
        chk("t4_post_ready", 64'(IN_READY), 64'd1);
        adv();
        drain("t4");
        chk("t4_alone", 64'(n_out - base_out), 64'd1);

        // Asynchronous reset mid-stream.
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, DW'(32'h300 + c), 1'b1);
            adv();
        end
        RSTN = 1'b0;
        IN_VALID = 1'b0;
        exp_q.delete();
        #1;
        chk("t5_rst_ready", 64'(IN_READY), 64'd0);
        chk("t5_rst_ovalid", 64'(OUT_VALID), 64'd0);
        chk("t5_rst_cen_wen", 64'({CENA, CENB, WENA, WENB}), 64'hF);
        chk("t5_rst_addr", 64'({AA, AB}), 64'd0);
        chk("t5_rst_odata", 64'(OUT_DATA), 64'd0);
        chk("t5_rst_level", 64'(LEVEL), 64'd0);
        @(negedge CLK);
        adv();
        RSTN = 1'b1;
        drive(1'b0, DW'(0), 1'b1);
        chk("t5_rel_ready", 64'(IN_READY), 64'd1);
        chk("t5_rel_ovalid", 64'(OUT_VALID), 64'd0);
        adv();
        sent = 0;
        k = 0;
        while (sent < 8 && k < 60) begin
            drive(1'b1, $urandom(), 1'($urandom_range(0, 1)));
            if (IN_READY) sent++;
            adv();
            k++;
        end
        chk("t5_sent", 64'(sent), 64'd8);
        drain("t5");

        // Steady state at LEVEL=3 with simultaneous IN and OUT every cycle.
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, DW'(32'h400 + c), 1'b0);
            adv();
        end
        for (int c = 0; c < 100; c++) begin
            drive(1'b1, DW'(32'h500 + c), 1'b1);
            chk("t6_level", 64'(LEVEL), 64'd3);
            chk("t6_both_xfer", 64'({IN_READY, OUT_VALID}), 64'd3);
            adv();
        end
        drive(1'b0, DW'(0), 1'b0);
        chk("t6_level_end", 64'(LEVEL), 64'd3);
        adv();
        chk("t6_no_collision", 64'(n_coll), 64'd0);
        drain("t6");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dpram_fifo_ctrl.md
DPRAM_FIFO_CTRL -- requirements
Module: dpram_fifo_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of stored words.
REQ-002 SHALL have parameter DEPTH, default 1024, RAM entries; power of two, at least 4.
REQ-003 SHALL have port CLK  input  1  single clock for all logic; paired DPRAM CLKA/CLKB tied to it.
REQ-004 SHALL have port RSTN  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port FLUSH  input  1  synchronous clear of all FIFO state.
REQ-006 SHALL have ports IN_VALID input 1, IN_READY output 1, IN_DATA input DATA_WIDTH, forming the upstream handshake.
REQ-007 SHALL have ports OUT_VALID output 1, OUT_READY input 1, OUT_DATA output DATA_WIDTH, forming the downstream handshake.
REQ-008 SHALL have port LEVEL  output  clog2(DEPTH)+2  words held (RAM + in-flight + output buffer).
REQ-009 SHALL have write-port drive outputs CENA 1, WENA 1, AA clog2(DEPTH), DA DATA_WIDTH to the DPRAM.
REQ-010 SHALL have read-port drive outputs CENB 1, WENB 1, AB clog2(DEPTH), and input QB DATA_WIDTH from the DPRAM.

Function
REQ-011 SHALL treat a transfer as VALID&&READY high at a rising CLK edge.
REQ-012 SHALL, on IN transfer, drive CENA=0, WENA=0, AA=wptr, DA=IN_DATA in that same cycle, then increment wptr modulo DEPTH.
REQ-013 SHALL hold CENA=1, WENA=1 in every cycle without an IN transfer.
REQ-014 SHALL drive IN_READY=1 iff ram_cnt (wptr-rptr entries not yet read) < DEPTH and FLUSH=0.
REQ-015 SHALL issue a read (CENB=0, WENB=1, AB=rptr, rptr+1 mod DEPTH) iff ram_cnt>0, FLUSH=0, and ob_cnt+inflight-(OUT transfer this cycle) < 2.
REQ-016 SHALL hold CENB=1, WENB=1 in every cycle without a read; QB SHALL be ignored except in the cycle after a read, as it is undefined otherwise.
REQ-017 SHALL capture QB into a 2-entry output buffer in the cycle after the read; OUT_VALID=1 iff ob_cnt>0; OUT_DATA=oldest entry.
REQ-018 SHALL give latency: IN transfer in cycle 0 into an empty FIFO -> OUT_VALID=1 in cycle 3 with that data.
REQ-019 SHALL sustain one IN and one OUT transfer per cycle once OUT is primed and OUT_READY stays high.
REQ-020 SHALL never issue read and write to the same address in one cycle (guaranteed by ram_cnt rules; assertion required).
REQ-021 SHALL hold OUT_DATA stable while OUT_VALID=1 and OUT_READY=0.
REQ-022 SHALL count LEVEL +1 per IN transfer and -1 per OUT transfer, both in one cycle net 0; the maximum is DEPTH+2.
REQ-023 SHALL, with FLUSH=1, force CENA=CENB=1, IN_READY=0, and on the next edge zero wptr, rptr, ob_cnt, inflight, LEVEL; any in-flight QB is discarded.
REQ-024 SHALL preserve FIFO order across pointer wrap-around at DEPTH-1 -> 0.

Reset
REQ-025 SHALL, while RSTN=0, asynchronously clear wptr, rptr, inflight, ob_cnt, LEVEL; OUT_VALID=0, IN_READY=0, CENA=CENB=1, WENA=WENB=1, AA=AB=0, DA=0, OUT_DATA=0.
REQ-026 SHALL raise IN_READY in the first cycle after RSTN deasserts; RAM contents are not cleared and never read before rewrite.
REQ-027 SHALL, on reset mid-operation, discard all queued and in-flight words with no spurious OUT transfer afterwards.

Structure
REQ-028 SHALL take pointer width clog2(DEPTH) and LEVEL width from a shared package of FIFO constants/functions.
REQ-029 SHALL place the 2-entry output buffer in sub-module dpram_fifo_obuf; the DPRAM itself is instantiated by the parent, not inside this block.

Verification
REQ-030 SHALL cover: reset, write 0x11,0x22,0x33 in consecutive cycles with OUT_READY=1 -> OUT_DATA 0x11,0x22,0x33 in cycles 3,4,5; LEVEL back to 0.
REQ-031 SHALL cover: DEPTH=4, OUT_READY=0, write 6 words -> IN_READY drops after the 6th word (4 RAM + 2 buffer), LEVEL=6; one OUT transfer -> IN_READY=1 within 2 cycles.
REQ-032 SHALL cover: DEPTH=4, 10 words streamed with OUT_READY toggling 1,0 each cycle -> output in order 0..9 across two pointer wraps, no loss or duplicate.
REQ-033 SHALL cover: FLUSH pulse for 1 cycle with LEVEL=5 and a read in flight -> next cycle LEVEL=0, OUT_VALID=0; the following write of 0xAB emerges alone.
REQ-034 SHALL cover: RSTN low for 1 cycle mid-stream -> all outputs at reset values immediately; a DPRAM model returning random QB on idle cycles never corrupts OUT_DATA.
REQ-035 SHALL cover: simultaneous IN and OUT transfers for 100 cycles at LEVEL=3 -> LEVEL stays 3, and the address-collision assertion never fires.
